// File: rtl/fetch_issue_ctrl.sv
// Fetch/issue sequencer: owns the PC, fetches words over req/ack and holds each until execute accepts it.
// Optional retire/stall counters are compiled in when FETCH_PERF_CNT_EN is defined.
module fetch_issue_ctrl #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_data,
  output logic [31:0]         inst,
  output logic                inst_valid,
  input  logic                exec_ready,
  input  logic                dec_is_branch,
  input  logic                dec_halted,
  input  logic                pred_taken,
  input  logic [31:0]         branch_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         retired_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         inst_q, inst_d;
  logic                inst_valid_q, inst_valid_d;
  logic                imem_req_q, imem_req_d;
  logic                halt_q, halt_d;
  logic                accept;
  logic                take_branch;

  assign accept      = (state_q == ISSUE) & inst_valid_q & exec_ready;
  assign take_branch = dec_is_branch & pred_taken;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0000_0000;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      imem_req_q   <= imem_req_d;
      halt_q       <= halt_d;
    end
  end

  // Next-state logic; next-cycle outputs are computed here so they leave the block registered.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    imem_req_d   = imem_req_q;
    halt_d       = halt_q;
    case (state_q)
      IDLE: begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
      end
      FETCH: begin
        if (imem_ack) begin
          inst_d       = imem_data;
          inst_valid_d = 1'b1;
          imem_req_d   = 1'b0;
          state_d      = ISSUE;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      ISSUE: begin
        if (accept) begin
          inst_valid_d = 1'b0;
          // HALT wins over any branch decode on the same word; the PC stays on the HALT.
          if (dec_halted) begin
            halt_d  = 1'b1;
            state_d = HALTED;
          end else if (take_branch) begin
            pc_d       = branch_target[PC_WIDTH-1:0];
            imem_req_d = 1'b1;
            state_d    = FETCH;
          end else begin
            pc_d       = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
            imem_req_d = 1'b1;
            state_d    = FETCH;
          end
        end else begin
          inst_valid_d = 1'b1;
        end
      end
      HALTED: begin
        imem_req_d   = 1'b0;
        inst_valid_d = 1'b0;
        halt_d       = 1'b1;
      end
      default: begin
        state_d      = IDLE;
        imem_req_d   = 1'b0;
        inst_valid_d = 1'b0;
        halt_d       = 1'b0;
      end
    endcase
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign halt       = halt_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_q, stall_d;
  logic        stall_cycle;

  assign stall_cycle = ((state_q == FETCH) & ~imem_ack) | ((state_q == ISSUE) & ~exec_ready);

  // Counter next values; HALTED never accepts or stalls, so both freeze there.
  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if (accept) begin
      retired_d = retired_q + 32'd1;
    end else begin
      retired_d = retired_q;
    end
    if (stall_cycle) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

  fetch_issue_ctrl_chk #(
    .PC_WIDTH (PC_WIDTH)
  ) u_chk (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req_q),
    .imem_addr  (pc_q),
    .imem_ack   (imem_ack),
    .inst       (inst_q),
    .inst_valid (inst_valid_q),
    .exec_ready (exec_ready),
    .pc         (pc_q),
    .halt       (halt_q)
  );

endmodule

// Protocol properties for the fetch/issue handshakes; no logic, observation only.
module fetch_issue_ctrl_chk #(
  parameter int PC_WIDTH = 16
) (
  input logic                clk,
  input logic                reset,
  input logic                imem_req,
  input logic [PC_WIDTH-1:0] imem_addr,
  input logic                imem_ack,
  input logic [31:0]         inst,
  input logic                inst_valid,
  input logic                exec_ready,
  input logic [PC_WIDTH-1:0] pc,
  input logic                halt
);

  a_req_hold: assert property (@(posedge clk)
    (!reset && imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

  a_inst_hold: assert property (@(posedge clk)
    (!reset && inst_valid && !exec_ready) |=> (inst_valid && $stable(inst) && $stable(pc)));

  a_halt_quiet: assert property (@(posedge clk)
    (!reset && halt) |=> (halt && !imem_req && !inst_valid));

  a_req_xor_valid: assert property (@(posedge clk)
    !(imem_req && inst_valid));

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Randomized scoreboard bench for fetch_issue_ctrl: a program-order PC model predicts fetch addresses, gaps and halts.
module tb_fetch_issue_ctrl;
  localparam int          PW  = 16;
  localparam logic [15:0] RST = 16'h0010;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack, inst_valid, exec_ready;
  logic        dec_is_branch, dec_halted, pred_taken, halt;
  logic [15:0] imem_addr, pc;
  logic [31:0] imem_data, inst, branch_target;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_issue_ctrl #(.PC_WIDTH(PW), .RESET_PC(RST)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .inst(inst), .inst_valid(inst_valid),
    .exec_ready(exec_ready), .dec_is_branch(dec_is_branch), .dec_halted(dec_halted),
    .pred_taken(pred_taken), .branch_target(branch_target), .pc(pc), .halt(halt)
`ifdef FETCH_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // kind: 0 sequential, 1 taken branch, 2 not-taken, 3 halt
  typedef struct { int ad; int rd; int kind; logic [31:0] tgt; } dir_t;
  typedef struct { logic [15:0] addr; int gap; } fexp_t;
  typedef struct { logic [15:0] pc; int ret; int stl; } hexp_t;

  dir_t        plan[$];
  dir_t        cur;
  fexp_t       fq[$];
  logic [31:0] iq[$];
  hexp_t       hq[$];
  int          ack_w, rdy_w, acc_m, stl_m;
  logic [15:0] pc_m;
  bit          drv_en, mon_en;
  int          checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic dir_t mk(input int ad, input int rd, input int kind, input logic [31:0] tgt);
    dir_t d;
    d.ad = ad; d.rd = rd; d.kind = kind; d.tgt = tgt;
    return d;
  endfunction

  function automatic void next_dir();
    if (plan.size() > 0) cur = plan.pop_front();
    else cur = mk(0, 0, 3, 32'h0);
    ack_w = cur.ad;
    rdy_w = cur.rd;
  endfunction

  function automatic void model_reset();
    fq.delete(); iq.delete(); hq.delete();
    pc_m = RST; acc_m = 0; stl_m = 0;
    fq.push_back('{RST, -1});
    next_dir();
  endfunction

  function automatic void add_random(input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      r = $urandom_range(0, 3);
      plan.push_back(mk($urandom_range(0, 3), $urandom_range(0, 3),
                        (r == 3) ? 2 : ((r == 2) ? 1 : 0), $urandom));
    end
    plan.push_back(mk(1, 2, 3, $urandom));
  endfunction

  // Driver: plays instruction memory and execute stage, and advances the model on each accept.
  always @(negedge clk) begin
    if (drv_en) begin
      if (reset) begin
        imem_ack = 1'b0; exec_ready = 1'b0;
      end else begin
        imem_data = $urandom; branch_target = $urandom;
        dec_is_branch = 1'($urandom); dec_halted = 1'($urandom); pred_taken = 1'($urandom);
        if (imem_req) begin
          if (ack_w == 0) begin imem_ack = 1'b1; iq.push_back(imem_data); end
          else begin imem_ack = 1'b0; ack_w--; end
        end else begin
          imem_ack = ($urandom_range(0, 3) == 0);
        end
        if (inst_valid) begin
          if (rdy_w == 0) begin
            exec_ready = 1'b1;
            acc_m++;
            stl_m += cur.ad + cur.rd;
            branch_target = cur.tgt;
            if (cur.kind == 3) begin
              dec_halted = 1'b1;
              hq.push_back('{pc_m, acc_m, stl_m});
            end else begin
              dec_halted = 1'b0;
              if (cur.kind == 1) begin
                dec_is_branch = 1'b1; pred_taken = 1'b1; pc_m = cur.tgt[15:0];
              end else if (cur.kind == 2) begin
                dec_is_branch = 1'($urandom); pred_taken = ~dec_is_branch; pc_m = pc_m + 16'd1;
              end else begin
                dec_is_branch = 1'b0; pc_m = pc_m + 16'd1;
              end
              fq.push_back('{pc_m, cur.ad + cur.rd + 2});
              next_dir();
            end
          end else begin
            exec_ready = 1'b0; rdy_w--;
          end
        end else begin
          exec_ready = 1'($urandom);
        end
      end
    end
  end

  int          cyc = 0, last_rise = 0;
  bit          pr, pv, ph;
  fexp_t       f;
  hexp_t       h;
  logic [15:0] ea;
  logic [31:0] ei;

  // Monitor: pops expectations whenever the DUT presents a fetch, an instruction or a halt.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!mon_en || reset) begin
      pr = 0; pv = 0; ph = 0;
    end else begin
      if (imem_req) begin
        if (!pr) begin
          if (fq.size() == 0) chk("unexpected_fetch", 32'(imem_addr), 32'hFFFF_FFFF);
          else begin
            f = fq.pop_front();
            ea = f.addr;
            if (f.gap >= 0) chk("fetch_gap", cyc - last_rise, f.gap);
            last_rise = cyc;
          end
        end
        chk("fetch_addr", 32'(imem_addr), 32'(ea));
        chk("fetch_pc", 32'(pc), 32'(ea));
      end
      if (inst_valid) begin
        if (!pv) begin
          if (iq.size() == 0) chk("unexpected_inst", inst, 32'hFFFF_FFFF);
          else ei = iq.pop_front();
        end
        chk("inst_word", inst, ei);
        chk("issue_pc", 32'(pc), 32'(ea));
      end
      if (halt) begin
        if (!ph) begin
          if (hq.size() == 0) chk("unexpected_halt", 32'(halt), 32'h0);
          else begin
            h = hq.pop_front();
            chk("halt_pc", 32'(pc), 32'(h.pc));
`ifdef FETCH_PERF_CNT_EN
            chk("retired_cnt", retired_cnt, h.ret);
            chk("stall_cnt", stall_cnt, h.stl);
`endif
          end
        end else begin
          chk("halt_no_req", 32'(imem_req), 32'h0);
          chk("halt_no_valid", 32'(inst_valid), 32'h0);
        end
      end
      pr = imem_req; pv = inst_valid; ph = halt;
    end
  end

  task automatic wait_halt(input string nm);
    for (int i = 0; i < 20000 && !halt; i++) @(negedge clk);
    chk(nm, 32'(halt), 32'h1);
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; exec_ready = 1'b0; imem_data = 32'h0;
    dec_is_branch = 1'b0; dec_halted = 1'b0; pred_taken = 1'b0; branch_target = 32'h0;
    drv_en = 0; mon_en = 0;
    repeat (3) plan.push_back(mk(0, 0, 0, 32'h0));        // 0x10..0x12 back to back
    plan.push_back(mk(3, 0, 0, 32'h0));                   // 0x13 memory stall
    plan.push_back(mk(0, 5, 1, 32'h0000_0004));           // 0x14 execute stall, jump to 4
    plan.push_back(mk(0, 0, 1, 32'hFFFF_0020));           // 0x04 taken -> 0x20
    plan.push_back(mk(1, 1, 1, 32'h1234_0004));           // 0x20 taken -> 0x04
    plan.push_back(mk(0, 0, 2, 32'hFFFF_0020));           // 0x04 not taken -> 0x05
    plan.push_back(mk(0, 0, 1, 32'h0000_FFFF));           // 0x05 -> 0xFFFF
    plan.push_back(mk(0, 0, 0, 32'h0));                   // 0xFFFF wraps -> 0x0000
    plan.push_back(mk(0, 0, 1, 32'hABCD_0000));           // branch to self
    plan.push_back(mk(2, 2, 0, 32'h0));
    add_random(250);
    model_reset();
    drv_en = 1; mon_en = 1;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_halt", 32'(halt), 32'h0);
    chk("rst_pc", 32'(pc), 32'(RST));
    chk("rst_inst", inst, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_retired", retired_cnt, 32'h0);
    chk("rst_stall", stall_cnt, 32'h0);
`endif
    reset = 1'b0;
    wait_halt("halt_reached_1");
    repeat (20) @(negedge clk);
    chk("halt_sticky", 32'(halt), 32'h1);
    chk("fetch_q_empty", fq.size(), 0);
    chk("inst_q_empty", iq.size(), 0);
    chk("halt_q_empty", hq.size(), 0);

    // Reset landing on the same edge as an ack must drop that ack.
    drv_en = 0; mon_en = 0;
    imem_ack = 1'b0; exec_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5 && !imem_req; i++) @(negedge clk);
    chk("restart_req", 32'(imem_req), 32'h1);
    chk("restart_addr", 32'(imem_addr), 32'(RST));
    imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF; reset = 1'b1;
    @(negedge clk);
    chk("midfetch_valid", 32'(inst_valid), 32'h0);
    chk("midfetch_req", 32'(imem_req), 32'h0);
    chk("midfetch_inst", inst, 32'h0);
    chk("midfetch_pc", 32'(pc), 32'(RST));
    chk("midfetch_halt", 32'(halt), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("midfetch_retired", retired_cnt, 32'h0);
    chk("midfetch_stall", stall_cnt, 32'h0);
`endif
    reset = 1'b0;
    @(negedge clk);
    chk("idle_then_fetch_req", 32'(imem_req), 32'h1);
    chk("idle_ack_ignored", 32'(inst_valid), 32'h0);
    imem_ack = 1'b0;

    @(negedge clk);
    reset = 1'b1;
    plan.delete();
    add_random(150);
    model_reset();
    drv_en = 1; mon_en = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_halt("halt_reached_2");
    repeat (5) @(negedge clk);
    chk("fetch_q_empty_2", fq.size(), 0);
    chk("inst_q_empty_2", iq.size(), 0);
    chk("halt_q_empty_2", hq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
